// File: rtl/waveform_player_mc.sv
// Multi-channel PCM player: prefetches interleaved samples from an Avalon-MM SDRAM
// controller and presents one frame at a time on per-channel ready/valid sinks.
module waveform_player_mc #(
   parameter int unsigned NUM_CHANNELS = 2,
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH   = 26,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                                 clock,
   input  logic                                 reset_n,
   input  logic [1:0]                           address,
   input  logic                                 write,
   input  logic [31:0]                          writedata,
   input  logic                                 read,
   output logic [31:0]                          readdata,
   input  logic [NUM_CHANNELS-1:0]              audio_ready,
   output logic [NUM_CHANNELS-1:0]              audio_valid,
   output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] audio_data,
   output logic [ADDR_WIDTH-1:0]                sdram_addr,
   output logic [SAMPLE_WIDTH/8-1:0]            sdram_byteenable_n,
   output logic                                 sdram_chipselect,
   output logic [SAMPLE_WIDTH-1:0]              sdram_writedata,
   output logic                                 sdram_read_n,
   output logic                                 sdram_write_n,
   input  logic [SAMPLE_WIDTH-1:0]              sdram_readdata,
   input  logic                                 sdram_readdata_valid,
   input  logic                                 sdram_waitrequest
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = 34 + $clog2(NUM_CHANNELS);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

   state_t                  state, next_state;
   logic [31:0]             max_index, base;
   logic [1:0]              ctrl;
   logic                    done, underrun, frame_seen;
   logic [ADDR_WIDTH-1:0]   base_l;
   logic [TW-1:0]           total_l, ptr;
   logic [CW-1:0]           outstanding, fifo_count;
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];

   logic ctrl_wr, start, stop, accept, last_word, can_issue, ret, push, pop, running, busy;

   assign ctrl_wr   = write && (address == 2'd1);
   assign running   = (state == FETCH) || (state == DRAIN);
   assign start     = ctrl_wr && writedata[0] && (state == IDLE);
   assign stop      = ctrl_wr && !writedata[0] && running;
   assign accept    = !sdram_read_n && !sdram_waitrequest;
   assign last_word = (ptr + TW'(1)) == total_l;
   assign can_issue = ((CW+1)'(fifo_count) + (CW+1)'(outstanding) < (CW+1)'(FIFO_DEPTH))
                      && (ptr < total_l);
   assign ret       = sdram_readdata_valid && (outstanding != '0);
   assign push      = ret && running;
   assign pop       = running && (audio_valid == '0) && (fifo_count >= CW'(NUM_CHANNELS));
   assign busy      = state != IDLE;

   assign sdram_byteenable_n = '0;
   assign sdram_writedata    = '0;
   assign sdram_write_n      = 1'b1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (start) next_state = FETCH;
         FETCH: begin
            if (stop) next_state = FLUSH;
            else if (accept && last_word && !ctrl[1]) next_state = DRAIN;
         end
         DRAIN: begin
            if (stop) next_state = FLUSH;
            else if (outstanding == '0 && fifo_count == '0 && audio_valid == '0)
               next_state = IDLE;
         end
         FLUSH: if (outstanding == '0 && sdram_read_n) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Sample storage has no reset; occupancy is tracked by the pointers below.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= sdram_readdata;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         max_index        <= '0;
         base             <= '0;
         ctrl             <= '0;
         done             <= 1'b0;
         underrun         <= 1'b0;
         frame_seen       <= 1'b0;
         readdata         <= '0;
         base_l           <= '0;
         total_l          <= '0;
         ptr              <= '0;
         outstanding      <= '0;
         fifo_count       <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         audio_valid      <= '0;
         audio_data       <= '0;
         sdram_addr       <= '0;
         sdram_chipselect <= 1'b0;
         sdram_read_n     <= 1'b1;
      end else begin
         if (write) begin
            case (address)
               2'd0:    max_index <= writedata;
               2'd1:    ctrl      <= writedata[1:0];
               2'd2:    base      <= writedata;
               default: ;
            endcase
         end
         if (read) begin
            case (address)
               2'd0:    readdata <= max_index;
               2'd1:    readdata <= {30'd0, ctrl};
               2'd2:    readdata <= base;
               default: readdata <= {16'd0, 8'(fifo_count), 5'd0, underrun, done, busy};
            endcase
         end
         if (start) begin
            base_l     <= ADDR_WIDTH'(base);
            total_l    <= TW'((TW'(max_index) + TW'(1)) * TW'(NUM_CHANNELS));
            ptr        <= '0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            frame_seen <= 1'b0;
         end
         if (state == DRAIN && next_state == IDLE) begin
            done    <= 1'b1;
            ctrl[0] <= 1'b0;
         end

         // A presented request is held until accepted, even once stopping.
         if (!sdram_read_n) begin
            if (!sdram_waitrequest) begin
               sdram_read_n     <= 1'b1;
               sdram_chipselect <= 1'b0;
               ptr              <= (last_word && ctrl[1]) ? '0 : ptr + TW'(1);
            end
         end else if (state == FETCH && !stop && can_issue) begin
            sdram_read_n     <= 1'b0;
            sdram_chipselect <= 1'b1;
            sdram_addr       <= base_l + ADDR_WIDTH'(ptr);
         end
         outstanding <= outstanding + CW'(accept) - CW'(ret);

         if (state == FLUSH) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(NUM_CHANNELS);
            fifo_count <= fifo_count + CW'(push) - (pop ? CW'(NUM_CHANNELS) : CW'(0));
         end

         if (!running) begin
            audio_valid <= '0;
         end else if (pop) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
               audio_data[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= mem[AW'(rd_ptr + AW'(c))];
            audio_valid <= '1;
            frame_seen  <= 1'b1;
         end else begin
            audio_valid <= audio_valid & ~audio_ready;
         end

         if (state == FETCH && audio_valid == '0 && (|audio_ready)
             && fifo_count < CW'(NUM_CHANNELS) && frame_seen)
            underrun <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(push && fifo_count == CW'(FIFO_DEPTH)));
`endif

endmodule

// File: tb/tb_waveform_player_mc.sv
// Directed bench for waveform_player_mc with a small SDRAM return model and sink logger.
module tb_waveform_player_mc;
   localparam int NC = 2;
   localparam int SW = 16;
   localparam int AW = 26;
   localparam int FD = 8;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [1:0]    address;
   logic          write, read;
   logic [31:0]   writedata, readdata;
   logic [NC-1:0] audio_ready, audio_valid;
   logic [NC*SW-1:0] audio_data;
   logic [AW-1:0] sdram_addr;
   logic [SW/8-1:0] sdram_byteenable_n;
   logic          sdram_chipselect, sdram_read_n, sdram_write_n;
   logic [SW-1:0] sdram_writedata;
   logic [SW-1:0] sdram_readdata = '0;
   logic          sdram_readdata_valid = 1'b0;
   logic          sdram_waitrequest = 1'b0;

   always #5 clock = ~clock;

   waveform_player_mc #(.NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
      .clock(clock), .reset_n(reset_n), .address(address), .write(write), .writedata(writedata),
      .read(read), .readdata(readdata), .audio_ready(audio_ready), .audio_valid(audio_valid),
      .audio_data(audio_data), .sdram_addr(sdram_addr), .sdram_byteenable_n(sdram_byteenable_n),
      .sdram_chipselect(sdram_chipselect), .sdram_writedata(sdram_writedata),
      .sdram_read_n(sdram_read_n), .sdram_write_n(sdram_write_n), .sdram_readdata(sdram_readdata),
      .sdram_readdata_valid(sdram_readdata_valid), .sdram_waitrequest(sdram_waitrequest));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // SDRAM model and sink logger state
   typedef struct { logic [AW-1:0] addr; int due; } rq_t;
   rq_t           rq[$];
   logic [AW-1:0] alog[$];
   logic [SW-1:0] ch0[$];
   logic [SW-1:0] ch1[$];
   int cyc = 0, lat = 3, wait_left = 0;
   int tb_out = 0, ret_cnt = 0, load_cnt = 0, stall_cnt = 0;
   bit occ_en = 1'b0;
   logic prev_req = 1'b0, prev_wait = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [NC-1:0] prev_valid = '0;

   always @(negedge clock) begin
      if (!reset_n) begin
         prev_req = 1'b0; prev_valid = '0; tb_out = 0;
      end else begin
         if (prev_req && prev_wait) begin
            chk("req_held", 32'(sdram_read_n), 32'd0);
            chk("addr_held", 32'(sdram_addr), 32'(prev_addr));
         end
         if (audio_valid == '1 && prev_valid == '0) load_cnt++;
         if (occ_en) chk("occupancy", 32'((ret_cnt - NC*load_cnt + tb_out) <= FD), 32'd1);
         if (audio_valid[0] && audio_ready[0]) ch0.push_back(audio_data[SW-1:0]);
         if (audio_valid[1] && audio_ready[1]) ch1.push_back(audio_data[2*SW-1:SW]);
         if (!sdram_read_n && sdram_waitrequest) stall_cnt++;
         if (!sdram_read_n && !sdram_waitrequest) begin
            alog.push_back(sdram_addr);
            rq.push_back('{sdram_addr, cyc + lat});
            tb_out++;
         end
         if (sdram_readdata_valid) begin
            if (tb_out > 0) tb_out--;
            ret_cnt++;
         end
         prev_req = !sdram_read_n; prev_wait = sdram_waitrequest;
         prev_addr = sdram_addr;   prev_valid = audio_valid;
      end
   end

   always @(posedge clock) begin
      #1;
      cyc++;
      if (!sdram_read_n && wait_left > 0) begin
         sdram_waitrequest = 1'b1; wait_left--;
      end else sdram_waitrequest = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         sdram_readdata_valid = 1'b1;
         sdram_readdata = SW'(rq[0].addr);
         void'(rq.pop_front());
      end else begin
         sdram_readdata_valid = 1'b0;
         sdram_readdata = '0;
      end
   end

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1;
      step();
      write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a; read = 1'b1;
      step();
      read = 1'b0;
      d = readdata;
   endtask

   task automatic wait_idle(input string name, input int budget);
      logic [31:0] s;
      s = 32'd1;
      for (int i = 0; i < budget; i++) begin
         rd(2'd3, s);
         if (!s[0]) break;
      end
      chk({name, "_reached_idle"}, 32'(s[0]), 32'd0);
   endtask

   task automatic drain_model();
      for (int i = 0; i < 200 && rq.size() > 0; i++) step();
      step(); step();
   endtask

   task automatic clear_logs();
      alog.delete(); ch0.delete(); ch1.delete();
      load_cnt = 0; ret_cnt = 0; stall_cnt = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct { bit wr; logic [1:0] a; logic [31:0] d; logic [31:0] exp; } reg_vec_t;
   typedef struct { logic [SW-1:0] c0; logic [SW-1:0] c1; } frame_t;
   reg_vec_t regv[12];
   frame_t   t1f[4];

   initial begin
      logic [31:0] s;
      regv[0]  = '{1'b0, 2'd0, 32'd0,          32'd0};
      regv[1]  = '{1'b0, 2'd1, 32'd0,          32'd0};
      regv[2]  = '{1'b0, 2'd2, 32'd0,          32'd0};
      regv[3]  = '{1'b0, 2'd3, 32'd0,          32'd0};
      regv[4]  = '{1'b1, 2'd0, 32'hdeadbeef,   32'd0};
      regv[5]  = '{1'b0, 2'd0, 32'd0,          32'hdeadbeef};
      regv[6]  = '{1'b1, 2'd2, 32'h0000_0100,  32'd0};
      regv[7]  = '{1'b0, 2'd2, 32'd0,          32'h0000_0100};
      regv[8]  = '{1'b1, 2'd1, 32'h0000_0002,  32'd0};
      regv[9]  = '{1'b0, 2'd1, 32'd0,          32'h0000_0002};
      regv[10] = '{1'b1, 2'd1, 32'h0000_0000,  32'd0};
      regv[11] = '{1'b0, 2'd3, 32'd0,          32'd0};
      t1f[0] = '{16'h0100, 16'h0101};
      t1f[1] = '{16'h0102, 16'h0103};
      t1f[2] = '{16'h0104, 16'h0105};
      t1f[3] = '{16'h0106, 16'h0107};

      reset_n = 1'b0; address = '0; write = 1'b0; read = 1'b0; writedata = '0; audio_ready = '0;
      repeat (3) step();
      chk("rst_valid", 32'(audio_valid), 32'd0);
      chk("rst_data", audio_data, 32'd0);
      chk("rst_read_n", 32'(sdram_read_n), 32'd1);
      chk("rst_cs", 32'(sdram_chipselect), 32'd0);
      chk("rst_addr", 32'(sdram_addr), 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 12; i++) begin
         if (regv[i].wr) wr(regv[i].a, regv[i].d);
         else begin
            rd(regv[i].a, s);
            chk($sformatf("reg_vec%0d", i), s, regv[i].exp);
         end
      end

      // 1: basic one-shot playback
      clear_logs(); lat = 3; audio_ready = 2'b11;
      wr(2'd0, 32'd3); wr(2'd2, 32'h100); wr(2'd1, 32'd1);
      wait_idle("t1", 300);
      chk("t1_reads", 32'(alog.size()), 32'd8);
      for (int i = 0; i < alog.size() && i < 8; i++) chk("t1_addr", 32'(alog[i]), 32'(32'h100 + i));
      chk("t1_frames", 32'(ch0.size()), 32'd4);
      for (int i = 0; i < 4 && i < ch0.size() && i < ch1.size(); i++) begin
         chk("t1_ch0", 32'(ch0[i]), 32'(t1f[i].c0));
         chk("t1_ch1", 32'(ch1[i]), 32'(t1f[i].c1));
      end
      rd(2'd3, s);
      chk("t1_done", 32'(s[1]), 32'd1);
      chk("t1_busy", 32'(s[0]), 32'd0);
      rd(2'd1, s);
      chk("t1_ctrl", s, 32'd0);
      drain_model();

      // 2: first read stalled by waitrequest
      clear_logs(); wait_left = 5; occ_en = 1'b1;
      wr(2'd2, 32'h200); wr(2'd1, 32'd1);
      wait_idle("t2", 300);
      occ_en = 1'b0;
      chk("t2_stalls", 32'(stall_cnt), 32'd5);
      chk("t2_reads", 32'(alog.size()), 32'd8);
      if (alog.size() > 0) chk("t2_first_addr", 32'(alog[0]), 32'h200);
      chk("t2_frames", 32'(ch1.size()), 32'd4);
      if (ch1.size() == 4) chk("t2_last_ch1", 32'(ch1[3]), 32'h207);
      drain_model();

      // 3: looping playback
      clear_logs();
      wr(2'd0, 32'd1); wr(2'd2, 32'h100); wr(2'd1, 32'd3);
      for (int i = 0; i < 1000 && ch0.size() < 20; i++) step();
      chk("t3_frames_reached", 32'(ch0.size() >= 20), 32'd1);
      rd(2'd3, s);
      chk("t3_no_done", 32'(s[1]), 32'd0);
      chk("t3_busy", 32'(s[0]), 32'd1);
      wr(2'd1, 32'd0);
      wait_idle("t3", 100);
      for (int i = 0; i < alog.size(); i++) chk("t3_addr", 32'(alog[i]), 32'(32'h100 + (i % 4)));
      for (int i = 0; i < 20 && i < ch0.size() && i < ch1.size(); i++) begin
         chk("t3_ch0", 32'(ch0[i]), 32'(32'h100 + 2 * (i % 2)));
         chk("t3_ch1", 32'(ch1[i]), 32'(32'h101 + 2 * (i % 2)));
      end
      rd(2'd3, s);
      chk("t3_done_after_stop", 32'(s[1]), 32'd0);
      drain_model();

      // 4: per-channel handshakes at different cycles
      clear_logs(); audio_ready = 2'b00;
      wr(2'd0, 32'd3); wr(2'd2, 32'h300); wr(2'd1, 32'd1);
      for (int i = 0; i < 100 && audio_valid != 2'b11; i++) step();
      chk("t4_first_valid", 32'(audio_valid), 32'd3);
      audio_ready = 2'b01;
      step();
      chk("t4_ch0_drop", 32'(audio_valid), 32'd2);
      audio_ready = 2'b00;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_hold", 32'(audio_valid), 32'd2);
      end
      audio_ready = 2'b10;
      step();
      chk("t4_ch1_drop", 32'(audio_valid), 32'd0);
      audio_ready = 2'b00;
      step();
      chk("t4_next_frame", 32'(audio_valid), 32'd3);
      audio_ready = 2'b11;
      wait_idle("t4", 300);
      chk("t4_frames", 32'(ch0.size()), 32'd4);
      for (int i = 0; i < 4 && i < ch0.size() && i < ch1.size(); i++) begin
         chk("t4_ch0", 32'(ch0[i]), 32'(32'h300 + 2 * i));
         chk("t4_ch1", 32'(ch1[i]), 32'(32'h301 + 2 * i));
      end
      drain_model();

      // 5: stop with reads outstanding
      clear_logs(); lat = 10; audio_ready = 2'b00;
      wr(2'd2, 32'h400); wr(2'd1, 32'd1);
      for (int i = 0; i < 50 && tb_out < 3; i++) step();
      chk("t5_three_out", 32'(tb_out), 32'd3);
      wr(2'd1, 32'd0);
      step(); step();
      chk("t5_valid_clear", 32'(audio_valid), 32'd0);
      s = 32'd1;
      for (int i = 0; i < 100; i++) begin
         rd(2'd3, s);
         if (tb_out > 0) chk("t5_busy_while_out", 32'(s[0]), 32'd1);
         if (!s[0]) break;
      end
      chk("t5_idle", 32'(s[0]), 32'd0);
      chk("t5_out_at_idle", 32'(tb_out), 32'd0);
      chk("t5_done", 32'(s[1]), 32'd0);
      chk("t5_fifo_count", 32'(s[15:8]), 32'd0);
      chk("t5_reads", 32'(alog.size()), 32'd3);
      chk("t5_no_frames", 32'(ch0.size() + ch1.size()), 32'd0);
      drain_model();

      // 6: slow SDRAM causes underrun; a new run clears it
      clear_logs(); lat = 20; audio_ready = 2'b11;
      wr(2'd0, 32'd15); wr(2'd2, 32'h500); wr(2'd1, 32'd1);
      wait_idle("t6", 2000);
      rd(2'd3, s);
      chk("t6_underrun", 32'(s[2]), 32'd1);
      chk("t6_done", 32'(s[1]), 32'd1);
      chk("t6_frames", 32'(ch0.size()), 32'd16);
      if (ch0.size() == 16 && ch1.size() == 16) begin
         chk("t6_last_ch0", 32'(ch0[15]), 32'h51e);
         chk("t6_last_ch1", 32'(ch1[15]), 32'h51f);
      end
      wr(2'd1, 32'd1);
      rd(2'd3, s);
      chk("t6_underrun_clr", 32'(s[2]), 32'd0);
      chk("t6_done_clr", 32'(s[1]), 32'd0);
      chk("t6_busy_again", 32'(s[0]), 32'd1);
      wr(2'd1, 32'd0);
      wait_idle("t6_stop", 200);
      drain_model();

      // 7: async reset mid-transfer, then stray returns
      clear_logs(); lat = 5; audio_ready = 2'b00;
      wr(2'd0, 32'd15); wr(2'd2, 32'h600); wr(2'd1, 32'd1);
      repeat (12) step();
      reset_n = 1'b0;
      #2;
      chk("t7_valid", 32'(audio_valid), 32'd0);
      chk("t7_data", audio_data, 32'd0);
      chk("t7_read_n", 32'(sdram_read_n), 32'd1);
      chk("t7_cs", 32'(sdram_chipselect), 32'd0);
      chk("t7_addr", 32'(sdram_addr), 32'd0);
      step();
      reset_n = 1'b1;
      ret_cnt = 0;
      repeat (15) step();
      chk("t7_strays_seen", 32'(ret_cnt > 0), 32'd1);
      chk("t7_no_valid", 32'(audio_valid), 32'd0);
      rd(2'd3, s); chk("t7_status", s, 32'd0);
      rd(2'd1, s); chk("t7_ctrl", s, 32'd0);
      rd(2'd2, s); chk("t7_base", s, 32'd0);
      rd(2'd0, s); chk("t7_max", s, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
